// File: rtl/jtag_phy_pkg.sv
// rtl/jtag_phy_pkg.sv - shared constants, state encoding and nbits clamp for the JTAG shift PHY
package jtag_phy_pkg;
  localparam int MAX_BITS = 8;
  localparam int NBITS_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] n);
    return (n > NBITS_W'(MAX_BITS)) ? NBITS_W'(MAX_BITS) : n;
  endfunction
endpackage

// File: rtl/jtag_shift_phy_if.sv
// rtl/jtag_shift_phy_if.sv - command and response channels between jtag_engine and the PHY
interface jtag_shift_phy_if;
  import jtag_phy_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [NBITS_W-1:0]  cmd_nbits;
  logic [MAX_BITS-1:0] cmd_tms;
  logic [MAX_BITS-1:0] cmd_tdi;
  logic                cmd_capture;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [MAX_BITS-1:0] rsp_tdo;

  modport master (
    output cmd_valid, cmd_nbits, cmd_tms, cmd_tdi, cmd_capture, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_tdo
  );

  modport slave (
    input  cmd_valid, cmd_nbits, cmd_tms, cmd_tdi, cmd_capture, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tdo
  );
endinterface

// File: rtl/tck_half_counter.sv
// rtl/tck_half_counter.sv - TCK half-period down-counter; one-cycle phase_done after TCK_DIV cycles
module tck_half_counter #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic phase_done
);
  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          armed;

  // armed keeps phase_done from re-firing while the PHY sits idle with cnt at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= CW'(TCK_DIV - 1);
      armed <= 1'b1;
    end else if (phase_done) begin
      armed <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign phase_done = armed && (cnt == '0);
endmodule

// File: rtl/jtag_shift_phy.sv
// rtl/jtag_shift_phy.sv - bit-level JTAG pin driver: shifts 1..8 TMS/TDI bits, captures TDO
module jtag_shift_phy
  import jtag_phy_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  jtag_shift_phy_if.slave  bus,
  output logic             busy,
  output logic             TCK,
  output logic             TMS,
  output logic             TDI,
  input  logic             TDO
);
  logic [1:0]          state;
  logic [2:0]          bit_idx;
  logic [NBITS_W-1:0]  nbits_q;
  logic [MAX_BITS-1:0] tms_q;
  logic [MAX_BITS-1:0] tdi_q;
  logic [MAX_BITS-1:0] shreg;
  logic                capture_q;
  logic [NBITS_W-1:0]  nbits_in;
  logic                accept;
  logic                last_bit;
  logic                load;
  logic                phase_done;

  assign nbits_in = clamp_nbits(bus.cmd_nbits);
  assign accept   = (state == ST_IDLE) && bus.cmd_ready && bus.cmd_valid;
  assign last_bit = ({1'b0, bit_idx} == (nbits_q - NBITS_W'(1)));
  assign load     = (accept && (nbits_in != '0)) ||
                    (phase_done && ((state == ST_LOW) || ((state == ST_HIGH) && !last_bit)));

  tck_half_counter #(.TCK_DIV(TCK_DIV)) u_half (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .phase_done (phase_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_idx       <= '0;
      nbits_q       <= '0;
      tms_q         <= '0;
      tdi_q         <= '0;
      shreg         <= '0;
      capture_q     <= 1'b0;
      TCK           <= 1'b0;
      TMS           <= 1'b1;
      TDI           <= 1'b0;
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_tdo   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.cmd_ready <= 1'b1;
          if (accept) begin
            tms_q     <= bus.cmd_tms;
            tdi_q     <= bus.cmd_tdi;
            nbits_q   <= nbits_in;
            capture_q <= bus.cmd_capture;
            shreg     <= '0;
            bit_idx   <= '0;
            if (nbits_in != '0) begin
              state         <= ST_LOW;
              TMS           <= bus.cmd_tms[0];
              TDI           <= bus.cmd_tdi[0];
              busy          <= 1'b1;
              bus.cmd_ready <= 1'b0;
            end else if (bus.cmd_capture) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_tdo   <= '0;
              busy          <= 1'b1;
              bus.cmd_ready <= 1'b0;
            end
          end
        end
        ST_LOW: begin
          // TDO is taken on the edge that raises TCK, i.e. the value seen while TCK was low
          if (phase_done) begin
            TCK            <= 1'b1;
            shreg[bit_idx] <= TDO;
            state          <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (phase_done) begin
            TCK <= 1'b0;
            if (!last_bit) begin
              bit_idx <= bit_idx + 3'd1;
              TMS     <= tms_q[bit_idx + 3'd1];
              TDI     <= tdi_q[bit_idx + 3'd1];
              state   <= ST_LOW;
            end else if (capture_q) begin
              state         <= ST_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_tdo   <= shreg;
            end else begin
              state         <= ST_IDLE;
              busy          <= 1'b0;
              bus.cmd_ready <= 1'b1;
            end
          end
        end
        default: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/jtag_shift_phy.md
Name: jtag_shift_phy

Overview:
Bit-level JTAG pin driver that sits directly downstream of jtag_engine and is the only block that toggles TCK, TMS and TDI.
- Accepts one shift command of 1..8 bits: TMS vector, TDI vector and a capture flag.
- Generates TCK at a divided rate and drives TMS/TDI LSB-first.
- Samples TDO on each TCK rising edge.
- Returns captured TDO bits on a valid/ready response channel.

Parameters:
TCK_DIV, 2, clk cycles per TCK half-period (legal ≥1); TCK period = 2*TCK_DIV clk cycles
MAX_BITS, 8, maximum bits per command; fixes vector widths

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command
cmd_nbits  in  4  bits to shift; 0 = no-op; values >8 clamp to 8
cmd_tms  in  8  TMS bit per TCK cycle, bit0 first
cmd_tdi  in  8  TDI bit per TCK cycle, bit0 first
cmd_capture  in  1  1 = return TDO response
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_tdo  out  8  captured TDO; bit i = sample of bit i; unused upper bits 0
busy  out  1  high in any state other than IDLE
TCK  out  1  JTAG clock
TMS  out  1  JTAG mode select
TDI  out  1  JTAG data in
TDO  in  1  JTAG data out from target

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, cmd_ready=0 during rst, rsp_valid=0, rsp_tdo=0, busy=0. cmd_ready goes high in the first cycle after rst deasserts.
- All outputs, including TCK/TMS/TDI, are registered, so the pins are glitch-free.
- States: IDLE, LOW, HIGH, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge T, latch vectors, the clamped bit count n and capture; clear the shift register.
  - If n=0: no TCK pulse. Go to RESP if capture (rsp_tdo=0), else stay in IDLE.
  - Otherwise go to LOW.
- LOW:
  - From cycle T+1, TCK=0 and TMS/TDI present bit i.
  - Lasts TCK_DIV cycles, then go to HIGH.
- HIGH:
  - TCK=1 for TCK_DIV cycles.
  - TDO is sampled into bit i on the same clk edge that sets TCK to 1, i.e. the value present while TCK was low.
  - At the end of the phase TCK returns to 0. If i<n-1, increment i and go to LOW with bit i+1 presented on that same edge.
  - After the last bit, go to RESP if capture, else IDLE. TMS/TDI hold the last bit's values until the next command.
- Timing:
  - Each bit takes exactly 2*TCK_DIV clk cycles.
  - The first rising TCK edge is at T+1+TCK_DIV.
  - The block returns to IDLE (or RESP) at T+1+2*n*TCK_DIV.
- RESP:
  - rsp_valid=1 and rsp_tdo stable until rsp_valid&rsp_ready.
  - cmd_ready=0 throughout (no overlap with responses).
  - After the handshake, go to IDLE, clear rsp_valid and keep rsp_tdo unchanged.
- Back-to-back: a non-capture command accepted in IDLE immediately after completion gives a gap of exactly 1 clk, the acceptance cycle, with TCK low between commands.
- Reset mid-shift: on the next edge, abort, force the reset values and drop any pending response.
- cmd_* inputs are ignored while cmd_ready=0. The vectors are latched, so upstream may change them after the handshake.

Decomposition:
- Package jtag_phy_pkg holds:
  - the state enum (IDLE/LOW/HIGH/RESP);
  - MAX_BITS;
  - NBITS_W=4;
  - the clamp function for nbits.
- One sub-module, tck_half_counter: a down-counter loaded with TCK_DIV-1 that emits a one-cycle phase_done pulse. It is reloaded on every phase entry.

Test Plan:
- TCK_DIV=2: nbits=5, tms=0x06, tdi=0x15, capture=1. The TDO model drives 1,0,1,1,0 on bits 0..4.
  - Expect 5 TCK pulses, each period 4 clk; first rise at T+3.
  - TMS sequence 0,1,1,0,0 and TDI sequence 1,0,1,0,1.
  - rsp_tdo=0x0D; rsp_valid at T+21.
- Response backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid. Expect rsp_valid and rsp_tdo stable, cmd_ready=0 and no TCK activity; one handshake then returns to IDLE.
- nbits=0 with capture=1: no TCK edge, rsp_valid at T+1 with rsp_tdo=0x00. nbits=12, capture=0: exactly 8 TCK pulses.
- Back-to-back non-capture commands, nbits=8 each, TCK_DIV=1: 16 pulses total, with a single 1-clk TCK-low gap between the commands.
- Assert rst during the 3rd HIGH phase: the next edge gives TCK=0, TMS=1, TDI=0, busy=0; no rsp_valid appears afterwards; cmd_ready=1 in the cycle after rst deasserts.
- TDO sampling: the TDO model changes TDO only on TCK falling edges and drives a glitch value during the HIGH phase. Expect the captured bits to equal the pre-rise values.
